// File: rtl/simon_control_pkg.sv
// Shared state encoding, mode-LED codes and strobe bundle for the Simon sequencer.
package simon_control_pkg;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
  localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
  localparam logic [2:0] LED_MODE_DONE     = 3'b111;

  typedef struct packed {
    logic clear_i;
    logic increment_n;
    logic increment_i;
    logic input_led_pattern;
    logic write_pattern;
  } strobe_t;

  // Mode LEDs are a pure decode of the state register.
  function automatic logic [2:0] mode_leds_of(input state_e s);
    logic [2:0] m;
    case (s)
      ST_INPUT:    m = LED_MODE_INPUT;
      ST_PLAYBACK: m = LED_MODE_PLAYBACK;
      ST_REPEAT:   m = LED_MODE_REPEAT;
      ST_DONE:     m = LED_MODE_DONE;
      default:     m = LED_MODE_INPUT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/simon_control.sv
// Simon game-sequencing FSM: drives SimonDatapath strobes (Mealy) from state and
// datapath status, tracks stored-sequence length and latches the win condition.
module simon_control
  import simon_control_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seq_remain,
  input  logic       valid_repeat,
  input  logic       valid_input,
  output logic       clear_i,
  output logic       increment_n,
  output logic       increment_i,
  output logic       input_led_pattern,
  output logic       write_pattern,
  output logic [2:0] mode_leds,
  output logic       win
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               win_q, win_d;
  logic               len_full;
  strobe_t            strb;

  assign len_full = (len_q == LEN_W'(MAX_LEN));

  // State, length and win registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INPUT;
      len_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      win_q   <= win_d;
    end
  end

  // Next state and Mealy strobes; exactly one of clear_i/increment_i is set per path.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    win_d   = win_q;
    strb    = '0;

    case (state_q)
      ST_INPUT: begin
        strb.input_led_pattern = 1'b1;
        strb.clear_i           = 1'b1;
        if (valid_input) begin
          strb.write_pattern = 1'b1;
          strb.increment_n   = 1'b1;
          len_d              = len_q + LEN_W'(1);
          state_d            = ST_PLAYBACK;
        end
      end
      ST_PLAYBACK: begin
        if (seq_remain) begin
          strb.increment_i = 1'b1;
        end else begin
          strb.clear_i = 1'b1;
          state_d      = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        strb.input_led_pattern = 1'b1;
        if (!seq_remain) begin
          strb.clear_i = 1'b1;
          if (len_full) begin
            win_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_INPUT;
          end
        end else if (valid_repeat) begin
          strb.increment_i = 1'b1;
        end else begin
          strb.clear_i = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        // Endless playback of the stored sequence until reset.
        if (seq_remain) begin
          strb.increment_i = 1'b1;
        end else begin
          strb.clear_i = 1'b1;
        end
      end
    endcase

    if (rst) begin
      strb         = '0;
      strb.clear_i = 1'b1;
    end
  end

  assign clear_i           = strb.clear_i;
  assign increment_n       = strb.increment_n;
  assign increment_i       = strb.increment_i;
  assign input_led_pattern = strb.input_led_pattern;
  assign write_pattern     = strb.write_pattern;
  assign mode_leds         = rst ? LED_MODE_INPUT : mode_leds_of(state_q);
  assign win               = win_q & ~rst;

endmodule

// File: tb/tb_simon_control.sv
// Directed bench for simon_control; two instances (long and MAX_LEN=2) each paired
// with a small behavioural SimonDatapath model (index i, count n, pattern memory).
module tb_simon_control;

  typedef struct packed {
    logic       rst;
    logic [3:0] pat;
    logic       vin;
    logic [8:0] exp;
    logic       chk_led;
    logic [3:0] led;
  } step_t;

  // {clear_i, increment_n, increment_i, input_led_pattern, write_pattern, mode_leds, win}
  localparam logic [8:0] RST      = 9'b1_0_0_0_0_001_0;
  localparam logic [8:0] IN_IDLE  = 9'b1_0_0_1_0_001_0;
  localparam logic [8:0] IN_VALID = 9'b1_1_0_1_1_001_0;
  localparam logic [8:0] PB_REM   = 9'b0_0_1_0_0_010_0;
  localparam logic [8:0] PB_END   = 9'b1_0_0_0_0_010_0;
  localparam logic [8:0] RP_MATCH = 9'b0_0_1_1_0_100_0;
  localparam logic [8:0] RP_END   = 9'b1_0_0_1_0_100_0;
  localparam logic [8:0] DN_REM   = 9'b0_0_1_0_0_111_0;
  localparam logic [8:0] DN_END   = 9'b1_0_0_0_0_111_0;
  localparam logic [8:0] DN_REM_W = 9'b0_0_1_0_0_111_1;
  localparam logic [8:0] DN_END_W = 9'b1_0_0_0_0_111_1;

  logic clk;
  int   checks;
  int   failures;

  // Instance A: MAX_LEN=4
  logic       rst_a, valid_input_a, seq_remain_a, valid_repeat_a;
  logic       clear_i_a, increment_n_a, increment_i_a, input_led_pattern_a, write_pattern_a, win_a;
  logic [2:0] mode_leds_a;
  logic [3:0] pattern_a, i_a, n_a, led_a;
  logic [3:0] mem_a [16];
  logic [8:0] obs_a;

  // Instance B: MAX_LEN=2
  logic       rst_b, valid_input_b, seq_remain_b, valid_repeat_b;
  logic       clear_i_b, increment_n_b, increment_i_b, input_led_pattern_b, write_pattern_b, win_b;
  logic [2:0] mode_leds_b;
  logic [3:0] pattern_b, i_b, n_b, led_b;
  logic [3:0] mem_b [16];
  logic [8:0] obs_b;

  simon_control #(.MAX_LEN(4), .LEN_W(3)) dut_a (
    .clk(clk), .rst(rst_a),
    .seq_remain(seq_remain_a), .valid_repeat(valid_repeat_a), .valid_input(valid_input_a),
    .clear_i(clear_i_a), .increment_n(increment_n_a), .increment_i(increment_i_a),
    .input_led_pattern(input_led_pattern_a), .write_pattern(write_pattern_a),
    .mode_leds(mode_leds_a), .win(win_a)
  );

  simon_control #(.MAX_LEN(2), .LEN_W(2)) dut_b (
    .clk(clk), .rst(rst_b),
    .seq_remain(seq_remain_b), .valid_repeat(valid_repeat_b), .valid_input(valid_input_b),
    .clear_i(clear_i_b), .increment_n(increment_n_b), .increment_i(increment_i_b),
    .input_led_pattern(input_led_pattern_b), .write_pattern(write_pattern_b),
    .mode_leds(mode_leds_b), .win(win_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath models
  assign seq_remain_a   = (i_a < n_a);
  assign valid_repeat_a = (mem_a[i_a] == pattern_a);
  assign led_a          = input_led_pattern_a ? pattern_a : mem_a[i_a];
  assign obs_a = {clear_i_a, increment_n_a, increment_i_a, input_led_pattern_a,
                  write_pattern_a, mode_leds_a, win_a};

  always @(posedge clk) begin
    if (rst_a) begin
      i_a <= 4'd0;
      n_a <= 4'd0;
    end else begin
      if (clear_i_a) i_a <= 4'd0;
      else if (increment_i_a) i_a <= i_a + 4'd1;
      if (write_pattern_a) mem_a[n_a] <= pattern_a;
      if (increment_n_a) n_a <= n_a + 4'd1;
    end
  end

  assign seq_remain_b   = (i_b < n_b);
  assign valid_repeat_b = (mem_b[i_b] == pattern_b);
  assign led_b          = input_led_pattern_b ? pattern_b : mem_b[i_b];
  assign obs_b = {clear_i_b, increment_n_b, increment_i_b, input_led_pattern_b,
                  write_pattern_b, mode_leds_b, win_b};

  always @(posedge clk) begin
    if (rst_b) begin
      i_b <= 4'd0;
      n_b <= 4'd0;
    end else begin
      if (clear_i_b) i_b <= 4'd0;
      else if (increment_i_b) i_b <= i_b + 4'd1;
      if (write_pattern_b) mem_b[n_b] <= pattern_b;
      if (increment_n_b) n_b <= n_b + 4'd1;
    end
  end

  task automatic test_reset();
    step_t t [2] = '{
      '{1'b1, 4'b0000, 1'b1, RST,     1'b0, 4'b0000},
      '{1'b0, 4'b0101, 1'b0, IN_IDLE, 1'b0, 4'b0000}
    };
    foreach (t[k]) begin
      @(negedge clk);
      rst_a = t[k].rst; pattern_a = t[k].pat; valid_input_a = t[k].vin;
      #1;
      checks++;
      if (obs_a !== t[k].exp) begin
        failures++;
        $display("FAIL test_reset step %0d outputs got %b want %b", k, obs_a, t[k].exp);
      end
    end
  endtask

  task automatic test_illegal_input();
    step_t t [3] = '{
      '{1'b0, 4'b1111, 1'b0, IN_IDLE, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, IN_IDLE, 1'b0, 4'b0000},
      '{1'b0, 4'b1010, 1'b0, IN_IDLE, 1'b0, 4'b0000}
    };
    foreach (t[k]) begin
      @(negedge clk);
      rst_a = t[k].rst; pattern_a = t[k].pat; valid_input_a = t[k].vin;
      #1;
      checks++;
      if (obs_a !== t[k].exp) begin
        failures++;
        $display("FAIL test_illegal_input step %0d outputs got %b want %b", k, obs_a, t[k].exp);
      end
    end
    @(negedge clk);
    checks++;
    if (n_a !== 4'd0) begin
      failures++;
      $display("FAIL test_illegal_input stored_count got %0d want 0", n_a);
    end
  endtask

  task automatic test_round1();
    step_t t [6] = '{
      '{1'b0, 4'b1001, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b1001},
      '{1'b0, 4'b0000, 1'b0, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b1001, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b1001, 1'b0, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, IN_IDLE,  1'b0, 4'b0000}
    };
    foreach (t[k]) begin
      @(negedge clk);
      rst_a = t[k].rst; pattern_a = t[k].pat; valid_input_a = t[k].vin;
      #1;
      checks++;
      if (obs_a !== t[k].exp) begin
        failures++;
        $display("FAIL test_round1 step %0d outputs got %b want %b", k, obs_a, t[k].exp);
      end
      if (t[k].chk_led) begin
        checks++;
        if (led_a !== t[k].led) begin
          failures++;
          $display("FAIL test_round1 step %0d leds got %b want %b", k, led_a, t[k].led);
        end
      end
    end
  endtask

  task automatic test_mistake();
    step_t t [18] = '{
      '{1'b1, 4'b0000, 1'b0, RST,      1'b0, 4'b0000},
      '{1'b0, 4'b1001, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b1001},
      '{1'b0, 4'b0000, 1'b0, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b1001, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0110, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b1001},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b0110},
      '{1'b0, 4'b0000, 1'b0, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b1001, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b1111, 1'b0, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b1111, 1'b1, DN_REM,   1'b1, 4'b1001},
      '{1'b0, 4'b1111, 1'b1, DN_REM,   1'b1, 4'b0110},
      '{1'b0, 4'b1111, 1'b1, DN_END,   1'b0, 4'b0000},
      '{1'b0, 4'b1111, 1'b1, DN_REM,   1'b1, 4'b1001},
      '{1'b0, 4'b1111, 1'b1, DN_REM,   1'b1, 4'b0110},
      '{1'b0, 4'b1111, 1'b1, DN_END,   1'b0, 4'b0000}
    };
    foreach (t[k]) begin
      @(negedge clk);
      rst_a = t[k].rst; pattern_a = t[k].pat; valid_input_a = t[k].vin;
      #1;
      checks++;
      if (obs_a !== t[k].exp) begin
        failures++;
        $display("FAIL test_mistake step %0d outputs got %b want %b", k, obs_a, t[k].exp);
      end
      if (t[k].chk_led) begin
        checks++;
        if (led_a !== t[k].led) begin
          failures++;
          $display("FAIL test_mistake step %0d leds got %b want %b", k, led_a, t[k].led);
        end
      end
    end
  endtask

  task automatic test_win();
    step_t t [17] = '{
      '{1'b1, 4'b0000, 1'b0, RST,      1'b0, 4'b0000},
      '{1'b0, 4'b0011, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, PB_REM,   1'b1, 4'b0011},
      '{1'b0, 4'b0000, 1'b1, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0011, 1'b1, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0101, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, PB_REM,   1'b1, 4'b0011},
      '{1'b0, 4'b0000, 1'b1, PB_REM,   1'b1, 4'b0101},
      '{1'b0, 4'b0000, 1'b1, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0011, 1'b1, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0101, 1'b1, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b1111, 1'b1, DN_REM_W, 1'b1, 4'b0011},
      '{1'b0, 4'b1111, 1'b1, DN_REM_W, 1'b1, 4'b0101},
      '{1'b0, 4'b1111, 1'b1, DN_END_W, 1'b0, 4'b0000},
      '{1'b0, 4'b1111, 1'b1, DN_REM_W, 1'b1, 4'b0011}
    };
    foreach (t[k]) begin
      @(negedge clk);
      rst_b = t[k].rst; pattern_b = t[k].pat; valid_input_b = t[k].vin;
      #1;
      checks++;
      if (obs_b !== t[k].exp) begin
        failures++;
        $display("FAIL test_win step %0d outputs got %b want %b", k, obs_b, t[k].exp);
      end
      if (t[k].chk_led) begin
        checks++;
        if (led_b !== t[k].led) begin
          failures++;
          $display("FAIL test_win step %0d leds got %b want %b", k, led_b, t[k].led);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (n_b !== 4'd2) begin
      failures++;
      $display("FAIL test_win stored_count got %0d want 2", n_b);
    end
  endtask

  task automatic test_reset_mid_repeat();
    step_t t [27] = '{
      '{1'b1, 4'b0000, 1'b0, RST,      1'b0, 4'b0000},
      '{1'b0, 4'b0001, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b0001},
      '{1'b0, 4'b0000, 1'b0, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0001, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0010, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b0001},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b0010},
      '{1'b0, 4'b0000, 1'b0, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0001, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0010, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0100, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b0001},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b0010},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b0100},
      '{1'b0, 4'b0000, 1'b0, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0001, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b1, 4'b0010, 1'b0, RST,      1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, IN_IDLE,  1'b0, 4'b0000},
      '{1'b0, 4'b1100, 1'b1, IN_VALID, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, PB_REM,   1'b1, 4'b1100},
      '{1'b0, 4'b0000, 1'b0, PB_END,   1'b0, 4'b0000},
      '{1'b0, 4'b1100, 1'b0, RP_MATCH, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, RP_END,   1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, IN_IDLE,  1'b0, 4'b0000}
    };
    foreach (t[k]) begin
      @(negedge clk);
      rst_a = t[k].rst; pattern_a = t[k].pat; valid_input_a = t[k].vin;
      #1;
      checks++;
      if (obs_a !== t[k].exp) begin
        failures++;
        $display("FAIL test_reset_mid_repeat step %0d outputs got %b want %b", k, obs_a, t[k].exp);
      end
      if (t[k].chk_led) begin
        checks++;
        if (led_a !== t[k].led) begin
          failures++;
          $display("FAIL test_reset_mid_repeat step %0d leds got %b want %b", k, led_a, t[k].led);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (n_a !== 4'd1) begin
      failures++;
      $display("FAIL test_reset_mid_repeat stored_count got %0d want 1", n_a);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_a         = 1'b1;
    rst_b         = 1'b1;
    pattern_a     = 4'd0;
    pattern_b     = 4'd0;
    valid_input_a = 1'b0;
    valid_input_b = 1'b0;

    test_reset();
    test_illegal_input();
    test_round1();
    test_mistake();
    test_win();
    test_reset_mid_repeat();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
